// File: rtl/exmem_wb_if.sv
// EXMEM -> WB pipeline boundary: the EXMEM result and control signals in, the
// registered writeback entry, the forwarding selects and the retire count out.
interface exmem_wb_if #(
    parameter int unsigned RETIRE_W = 32
);
    logic [0:63]         EXMEM_ALU_out;
    logic [0:63]         dmem_data_out;
    logic                EXMEM_rD_data_select;
    logic                EXMEM_stall;
    logic [0:4]          EXMEM_rD;
    logic                EXMEM_wrEn;
    logic [0:2]          EXMEM_ppp;
    logic [0:4]          EXMEM_rA;
    logic [0:4]          EXMEM_rB;

    logic [0:63]         WB_data;
    logic [0:2]          WB_ppp;
    logic [0:4]          WB_rD;
    logic                WB_wrEn;
    logic                EXMEM_forward_rA;
    logic                EXMEM_forward_rB;
    logic [RETIRE_W-1:0] WB_retired;

    modport master (
        output EXMEM_ALU_out, dmem_data_out, EXMEM_rD_data_select, EXMEM_stall,
        output EXMEM_rD, EXMEM_wrEn, EXMEM_ppp, EXMEM_rA, EXMEM_rB,
        input  WB_data, WB_ppp, WB_rD, WB_wrEn, EXMEM_forward_rA, EXMEM_forward_rB,
        input  WB_retired
    );

    modport slave (
        input  EXMEM_ALU_out, dmem_data_out, EXMEM_rD_data_select, EXMEM_stall,
        input  EXMEM_rD, EXMEM_wrEn, EXMEM_ppp, EXMEM_rA, EXMEM_rB,
        output WB_data, WB_ppp, WB_rD, WB_wrEn, EXMEM_forward_rA, EXMEM_forward_rB,
        output WB_retired
    );
endinterface

// File: rtl/exmem_wb.sv
// EXMEM/WB pipeline register: selects ALU or memory data, loads a bubble on a load
// stall, qualifies the register write by participation field, and forwards to EXMEM.
module exmem_wb #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    exmem_wb_if.slave  bus
);
    logic [0:63]         r_data;
    logic [0:2]          r_ppp;
    logic [0:4]          r_rd;
    logic                r_wr_en;
    logic [RETIRE_W-1:0] r_retired;

    logic [0:63]         w_sel_data;
    logic                w_ppp_legal;
    logic                w_wr_en;

    assign w_sel_data  = bus.EXMEM_rD_data_select ? bus.dmem_data_out : bus.EXMEM_ALU_out;
    // Encodings 101..111 are reserved: the entry is kept but never writes back.
    assign w_ppp_legal = (bus.EXMEM_ppp <= 3'b100);
    assign w_wr_en     = bus.EXMEM_wrEn & ~bus.EXMEM_stall & w_ppp_legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data    <= '0;
            r_ppp     <= '0;
            r_rd      <= '0;
            r_wr_en   <= 1'b0;
            r_retired <= '0;
        end else begin
            if (bus.EXMEM_stall) begin
                r_data  <= '0;
                r_ppp   <= '0;
                r_rd    <= '0;
                r_wr_en <= 1'b0;
            end else begin
                r_data  <= w_sel_data;
                r_ppp   <= bus.EXMEM_ppp;
                r_rd    <= bus.EXMEM_rD;
                r_wr_en <= w_wr_en;
            end
            // Free-running count; wraps silently.
            if (w_wr_en) begin
                r_retired <= r_retired + RETIRE_W'(1);
            end
        end
    end

    assign bus.WB_data          = r_data;
    assign bus.WB_ppp           = r_ppp;
    assign bus.WB_rD            = r_rd;
    assign bus.WB_wrEn          = r_wr_en;
    assign bus.WB_retired       = r_retired;
    assign bus.EXMEM_forward_rA = r_wr_en & (r_rd == bus.EXMEM_rA);
    assign bus.EXMEM_forward_rB = r_wr_en & (r_rd == bus.EXMEM_rB);
endmodule

// File: tb/tb_exmem_wb.sv
// Bench for exmem_wb: directed cases plus random traffic against a
// transaction-level model of the writeback entry and retire count.
module tb_exmem_wb;
    localparam int unsigned RW = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Reference model: the WB entry that should be visible after each edge.
    logic [63:0] m_data;
    int          m_rd;
    int          m_ppp;
    bit          m_wr;
    int          m_ret;

    exmem_wb_if #(.RETIRE_W(RW)) bus ();

    exmem_wb #(.RETIRE_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit fa;
        bit fb;
        fa = m_wr && (m_rd == int'(bus.EXMEM_rA));
        fb = m_wr && (m_rd == int'(bus.EXMEM_rB));
        chk({tag, ".data"}, 64'(bus.WB_data), m_data);
        chk({tag, ".rd"}, 64'(bus.WB_rD), 64'(m_rd));
        chk({tag, ".ppp"}, 64'(bus.WB_ppp), 64'(m_ppp));
        chk({tag, ".wren"}, 64'(bus.WB_wrEn), 64'(m_wr));
        chk({tag, ".retired"}, 64'(bus.WB_retired), 64'(m_ret));
        chk({tag, ".fwdA"}, 64'(bus.EXMEM_forward_rA), 64'(fa));
        chk({tag, ".fwdB"}, 64'(bus.EXMEM_forward_rB), 64'(fb));
    endtask

    task automatic model_reset();
        m_data = '0;
        m_rd   = 0;
        m_ppp  = 0;
        m_wr   = 1'b0;
        m_ret  = 0;
    endtask

    task automatic drive(input bit stall, input bit sel, input logic [63:0] alu,
                         input logic [63:0] dmem, input int rd, input bit wr,
                         input int ppp, input int ra, input int rb);
        bus.EXMEM_stall          = stall;
        bus.EXMEM_rD_data_select = sel;
        bus.EXMEM_ALU_out        = alu;
        bus.dmem_data_out        = dmem;
        bus.EXMEM_rD             = 5'(rd);
        bus.EXMEM_wrEn           = wr;
        bus.EXMEM_ppp            = 3'(ppp);
        bus.EXMEM_rA             = 5'(ra);
        bus.EXMEM_rB             = 5'(rb);
    endtask

    // One clock: the model applies the rules to what was presented, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (bus.EXMEM_stall) begin
            m_data = '0;
            m_rd   = 0;
            m_ppp  = 0;
            m_wr   = 1'b0;
        end else begin
            m_data = bus.EXMEM_rD_data_select ? bus.dmem_data_out : bus.EXMEM_ALU_out;
            m_rd   = int'(bus.EXMEM_rD);
            m_ppp  = int'(bus.EXMEM_ppp);
            m_wr   = bus.EXMEM_wrEn && (m_ppp < 5);
        end
        if (m_wr) m_ret = (m_ret + 1) % (1 << RW);
        #1;
        check_all(tag);
    endtask

    task automatic rand_drive();
        drive(($urandom_range(0, 3) == 0), 1'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, 31), 1'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0123456789ABCDEF, 64'h1, 5, 1'b1, 0, 5, 5);
        #3;
        check_all("in_reset");
        @(posedge clk);
        #1;
        check_all("in_reset_edge");
        #4 reset = 1'b1;

        // ALU op, no warm-up after release.
        drive(1'b0, 1'b0, 64'h0123456789ABCDEF, 64'h0, 5, 1'b1, 0, 9, 10);
        step("alu");
        chk("alu.retired_const", 64'(bus.WB_retired), 64'd1);

        // Load: stall cycle yields a bubble, valid cycle yields memory data.
        drive(1'b1, 1'b1, 64'h5555, 64'h0, 7, 1'b1, 0, 0, 0);
        step("load_stall");
        drive(1'b0, 1'b1, 64'h5555, 64'hDEADBEEF00000000, 7, 1'b1, 0, 1, 2);
        step("load_valid");
        chk("load.data_const", 64'(bus.WB_data), 64'hDEADBEEF00000000);
        chk("load.retired_const", 64'(bus.WB_retired), 64'd2);

        // Forwarding with even-byte participation.
        drive(1'b0, 1'b0, 64'hA5A5, 64'h0, 3, 1'b1, 3, 3, 4);
        step("fwd");
        chk("fwd.rA_const", 64'(bus.EXMEM_forward_rA), 64'd1);
        chk("fwd.rB_const", 64'(bus.EXMEM_forward_rB), 64'd0);

        // Reserved ppp suppresses the write but keeps data/rd/ppp.
        drive(1'b0, 1'b0, 64'hFACE, 64'h0, 8, 1'b1, 6, 8, 8);
        step("ppp110");
        chk("ppp110.retired_const", 64'(bus.WB_retired), 64'd3);

        // Register 0 still forwards.
        drive(1'b0, 1'b0, 64'h77, 64'h0, 0, 1'b1, 4, 0, 0);
        step("r0_fwd");

        // Stall wins over wrEn.
        drive(1'b1, 1'b0, 64'h99, 64'h0, 0, 1'b1, 0, 0, 0);
        step("stall_prio");

        // Back-to-back random traffic.
        for (int i = 0; i < 150; i++) begin
            rand_drive();
            step("rand");
        end

        // Wrap the retire counter.
        while (m_ret != (1 << RW) - 1) begin
            drive(1'b0, 1'b0, {$urandom, $urandom}, 64'h0, $urandom_range(0, 31), 1'b1,
                  $urandom_range(0, 4), 1, 2);
            step("preload");
        end
        drive(1'b0, 1'b0, 64'h1234, 64'h0, 9, 1'b1, 1, 9, 3);
        step("wrap");
        chk("wrap.retired_const", 64'(bus.WB_retired), 64'd0);

        // Reset between the stall and valid cycles of a load.
        drive(1'b0, 1'b0, 64'h42, 64'h0, 12, 1'b1, 2, 12, 0);
        step("pre_load");
        drive(1'b1, 1'b1, 64'h0, 64'h0, 13, 1'b1, 0, 13, 13);
        step("rst_load_stall");
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        drive(1'b0, 1'b1, 64'h0, 64'hCAFEF00D12345678, 13, 1'b1, 0, 13, 13);
        @(posedge clk);
        #1;
        check_all("held_reset");
        #2 reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0000000000BEEF01, 64'hCAFEF00D12345678, 14, 1'b1, 0, 14, 13);
        step("post_reset");
        chk("post_reset.retired_const", 64'(bus.WB_retired), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
